console_writer: RTL and testbench

- Writer side of the text-mode character buffer in main memory. The VGA wrapper reads this buffer; this block fills it.
- Accepts a stream of ASCII characters from the CPU IO path over a valid/ready handshake and tracks a cursor (row, col).
- Packs each character into the correct byte of the correct memory word using read-modify-write, so the display side sees an ordinary row-major buffer.
- Also provides a full-screen clear that writes spaces into every word of the buffer.

---
 rtl/console_writer_pkg.sv | 39 +++
 rtl/console_cursor.sv | 65 ++++++
 rtl/console_writer.sv | 201 ++++++++++++++++++++
 tb/tb_console_writer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_writer_pkg
// Description : Shared constants for the text-mode console writer. Contents:
//               screen geometry, the ASCII control codes the writer reacts to,
//               the writer FSM state type, and a printable-character helper.
// Revision    : 1.0 - initial release
// ============================================================================
package console_writer_pkg;

    // Display geometry, shared with the VGA reader side
    localparam int SCR_WORD_SIZE   = 32;
    localparam int SCR_ASCII_SIZE  = 8;
    localparam int SCR_CHARS_HORZ  = 80;
    localparam int SCR_CHARS_VERT  = 30;
    localparam int SCR_CPW         = SCR_WORD_SIZE / SCR_ASCII_SIZE;
    localparam int SCR_TOTAL_WORDS = SCR_CHARS_HORZ * SCR_CHARS_VERT / SCR_CPW;

    // Control codes interpreted by the writer
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_CLR   = 3'd4
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/console_cursor.sv
`default_nettype none
// ============================================================================
// Module      : console_cursor
// Description : Holds the console cursor (row, col) and applies one command
//               per cycle with wrap-around at the screen edges.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               zero              - home the cursor to (0,0) (highest priority)
//               inc               - advance one column, wrapping to next row
//               dec               - step back one column (no-op at col 0)
//               newline           - col=0, row+1 with wrap
//               carriage_ret      - col=0
//               row, col          - current cursor position
// Revision    : 1.0 - initial release
// ============================================================================
module console_cursor
    import console_writer_pkg::*;
#(
    parameter int CHARS_HORZ = SCR_CHARS_HORZ,
    parameter int CHARS_VERT = SCR_CHARS_VERT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          zero,
    input  logic                          inc,
    input  logic                          dec,
    input  logic                          newline,
    input  logic                          carriage_ret,
    output logic [$clog2(CHARS_VERT)-1:0] row,
    output logic [$clog2(CHARS_HORZ)-1:0] col
);

    localparam int ROW_W = $clog2(CHARS_VERT);
    localparam int COL_W = $clog2(CHARS_HORZ);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHARS_VERT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHARS_HORZ - 1);

    logic [ROW_W-1:0] w_row_next;

    assign w_row_next = (row == LAST_ROW) ? '0 : row + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || zero) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= w_row_next;
            end else begin
                col <= col + 1'b1;
            end
        end else if (dec) begin
            if (col != '0) begin
                col <= col - 1'b1;
            end
        end else if (newline) begin
            col <= '0;
            row <= w_row_next;
        end else if (carriage_ret) begin
            col <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/console_writer.sv
`default_nettype none
// ============================================================================
// Module      : console_writer
// Description : Writer side of the text-mode character buffer. Accepts ASCII
//               characters over valid/ready, tracks the cursor, and packs each
//               character into its byte of a row-major word buffer using a
//               read-modify-write. Also performs a full-screen clear to spaces.
// Ports       : clk, rst                   - clock, sync active-high reset
//               charValid/charData/charReady - character input handshake
//               clearReq                   - one-cycle clear request pulse
//               busy                       - FSM not idle
//               memReadEn/memReadAdd       - word read port (data 1 cycle later)
//               memDataRead                - read data
//               memWriteEn/memWriteAdd/memWriteData - word write port
//               cursorRow/cursorCol        - current cursor position
// Revision    : 1.0 - initial release
// ============================================================================
module console_writer
    import console_writer_pkg::*;
#(
    parameter int WORD_SIZE  = SCR_WORD_SIZE,
    parameter int ASCII_SIZE = SCR_ASCII_SIZE,
    parameter int CHARS_HORZ = SCR_CHARS_HORZ,
    parameter int CHARS_VERT = SCR_CHARS_VERT,
    parameter int BASE_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          charValid,
    input  logic [ASCII_SIZE-1:0]         charData,
    output logic                          charReady,
    input  logic                          clearReq,
    output logic                          busy,
    output logic                          memReadEn,
    output logic [WORD_SIZE-1:0]          memReadAdd,
    input  logic [WORD_SIZE-1:0]          memDataRead,
    output logic                          memWriteEn,
    output logic [WORD_SIZE-1:0]          memWriteAdd,
    output logic [WORD_SIZE-1:0]          memWriteData,
    output logic [$clog2(CHARS_VERT)-1:0] cursorRow,
    output logic [$clog2(CHARS_HORZ)-1:0] cursorCol
);

    localparam int WORD_CHARS   = WORD_SIZE / ASCII_SIZE;
    localparam int SCREEN_WORDS = CHARS_HORZ * CHARS_VERT / WORD_CHARS;
    localparam int ROW_W        = $clog2(CHARS_VERT);
    localparam int COL_W        = $clog2(CHARS_HORZ);
    localparam int BYTE_W       = (WORD_CHARS > 1) ? $clog2(WORD_CHARS) : 1;

    localparam logic [WORD_SIZE-1:0]  BASE_WORD  = WORD_SIZE'(BASE_ADDR);
    localparam logic [ASCII_SIZE-1:0] CHAR_SPACE = ASCII_SIZE'(ASCII_SPACE);
    localparam logic [WORD_SIZE-1:0]  SPACE_WORD = {WORD_CHARS{CHAR_SPACE}};
    localparam logic [WORD_SIZE-1:0]  LAST_WORD  = WORD_SIZE'(SCREEN_WORDS - 1);

    state_t                 r_state;
    logic                   r_clear_pending;
    logic [WORD_SIZE-1:0]   r_word_cnt;
    logic [WORD_SIZE-1:0]   r_tgt_addr;
    logic [BYTE_W-1:0]      r_tgt_byte;
    logic [ASCII_SIZE-1:0]  r_tgt_char;
    logic                   r_tgt_bs;

    logic                   w_clear_go;
    logic                   w_accept;
    logic                   w_printable;
    logic                   w_bs_ok;
    logic [COL_W-1:0]       w_col_eff;
    logic [WORD_SIZE-1:0]   w_lin;
    logic [WORD_SIZE-1:0]   w_word_off;
    logic [BYTE_W-1:0]      w_byte;
    logic [WORD_SIZE-1:0]   w_merged;
    logic                   w_clr_last;
    logic                   w_cur_zero;
    logic                   w_cur_inc;
    logic                   w_cur_dec;
    logic                   w_cur_nl;
    logic                   w_cur_cr;

    assign charReady = (r_state == ST_IDLE) && !r_clear_pending && !rst;
    assign busy      = (r_state != ST_IDLE);

    // A clear request seen in IDLE beats a simultaneous character, which is
    // therefore not consumed.
    assign w_clear_go = (r_state == ST_IDLE) && (r_clear_pending || clearReq);
    assign w_accept   = charValid && charReady && !clearReq;

    assign w_printable = is_printable(8'(charData));
    assign w_bs_ok     = (charData == ASCII_SIZE'(ASCII_BS)) && (cursorCol != '0);

    // Target position: backspace blanks the cell left of the cursor
    assign w_col_eff  = w_bs_ok ? cursorCol - 1'b1 : cursorCol;
    assign w_lin      = WORD_SIZE'(cursorRow) * WORD_SIZE'(CHARS_HORZ) + WORD_SIZE'(w_col_eff);
    assign w_word_off = w_lin / WORD_SIZE'(WORD_CHARS);
    assign w_byte     = BYTE_W'(w_lin % WORD_SIZE'(WORD_CHARS));

    // Byte 0 of a word sits in the MSBs so the display reads characters
    // left-to-right from the top of each word.
    always_comb begin
        w_merged = memDataRead;
        w_merged[WORD_SIZE-1-int'(r_tgt_byte)*ASCII_SIZE -: ASCII_SIZE] = r_tgt_char;
    end

    assign w_clr_last = (r_word_cnt == LAST_WORD);

    assign w_cur_zero = (r_state == ST_CLR) && w_clr_last;
    assign w_cur_inc  = (r_state == ST_WR) && !r_tgt_bs;
    assign w_cur_dec  = (r_state == ST_WR) && r_tgt_bs;
    assign w_cur_nl   = w_accept && (charData == ASCII_SIZE'(ASCII_LF));
    assign w_cur_cr   = w_accept && (charData == ASCII_SIZE'(ASCII_CR));

    console_cursor #(
        .CHARS_HORZ (CHARS_HORZ),
        .CHARS_VERT (CHARS_VERT)
    ) u_cursor (
        .clk          (clk),
        .rst          (rst),
        .zero         (w_cur_zero),
        .inc          (w_cur_inc),
        .dec          (w_cur_dec),
        .newline      (w_cur_nl),
        .carriage_ret (w_cur_cr),
        .row          (cursorRow),
        .col          (cursorCol)
    );

    // Strobes are registered on the transition into the state that owns
    // them, so each is high exactly for the cycle spent in RD / WR / CLR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_clear_pending <= 1'b0;
            r_word_cnt      <= '0;
            r_tgt_addr      <= '0;
            r_tgt_byte      <= '0;
            r_tgt_char      <= '0;
            r_tgt_bs        <= 1'b0;
            memReadEn       <= 1'b0;
            memReadAdd      <= '0;
            memWriteEn      <= 1'b0;
            memWriteAdd     <= '0;
            memWriteData    <= '0;
        end else begin
            // Requests during an operation are remembered; during CLR they
            // are absorbed by the clear already running.
            if (clearReq && (r_state != ST_IDLE) && (r_state != ST_CLR)) begin
                r_clear_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_clear_go) begin
                        r_state      <= ST_CLR;
                        r_word_cnt   <= '0;
                        memWriteEn   <= 1'b1;
                        memWriteAdd  <= BASE_WORD;
                        memWriteData <= SPACE_WORD;
                    end else if (w_accept && (w_printable || w_bs_ok)) begin
                        r_state    <= ST_RD;
                        r_tgt_addr <= BASE_WORD + w_word_off;
                        r_tgt_byte <= w_byte;
                        r_tgt_char <= w_bs_ok ? CHAR_SPACE : charData;
                        r_tgt_bs   <= w_bs_ok;
                        memReadEn  <= 1'b1;
                        memReadAdd <= BASE_WORD + w_word_off;
                    end
                end
                ST_RD: begin
                    memReadEn <= 1'b0;
                    r_state   <= ST_MERGE;
                end
                ST_MERGE: begin
                    memWriteEn   <= 1'b1;
                    memWriteAdd  <= r_tgt_addr;
                    memWriteData <= w_merged;
                    r_state      <= ST_WR;
                end
                ST_WR: begin
                    memWriteEn <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                ST_CLR: begin
                    if (w_clr_last) begin
                        memWriteEn      <= 1'b0;
                        r_clear_pending <= 1'b0;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_word_cnt  <= r_word_cnt + 1'b1;
                        memWriteAdd <= BASE_WORD + r_word_cnt + 1'b1;
                    end
                end
                default: begin
                    memReadEn  <= 1'b0;
                    memWriteEn <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_console_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_console_writer
// Description : Self-checking bench for console_writer. Drives directed and
//               random character streams, models the screen buffer as an
//               array of words and the cursor as (row, col) integers, and
//               compares strobes, addresses, data and cursor cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_console_writer;

    localparam int HORZ  = 80;
    localparam int VERT  = 30;
    localparam int TOTAL = 600;
    localparam int MEMW  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        charValid;
    logic [7:0]  charData;
    logic        charReady;
    logic        clearReq;
    logic        busy;
    logic        memReadEn;
    logic [31:0] memReadAdd;
    logic [31:0] memDataRead = '0;
    logic        memWriteEn;
    logic [31:0] memWriteAdd;
    logic [31:0] memWriteData;
    logic [4:0]  cursorRow;
    logic [6:0]  cursorCol;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    console_writer #(
        .WORD_SIZE  (32),
        .ASCII_SIZE (8),
        .CHARS_HORZ (HORZ),
        .CHARS_VERT (VERT),
        .BASE_ADDR  (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .charValid    (charValid),
        .charData     (charData),
        .charReady    (charReady),
        .clearReq     (clearReq),
        .busy         (busy),
        .memReadEn    (memReadEn),
        .memReadAdd   (memReadAdd),
        .memDataRead  (memDataRead),
        .memWriteEn   (memWriteEn),
        .memWriteAdd  (memWriteAdd),
        .memWriteData (memWriteData),
        .cursorRow    (cursorRow),
        .cursorCol    (cursorCol)
    );

    // Memory attached to the DUT: one-cycle read latency, one word write.
    logic [31:0] mem  [MEMW];
    logic [31:0] seed [MEMW];
    logic        mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < MEMW; i++) mem[i] <= seed[i];
        end else if (memWriteEn) begin
            mem[memWriteAdd[9:0]] <= memWriteData;
        end
        if (memReadEn) memDataRead <= mem[memReadAdd[9:0]];
        if (memReadEn && memWriteEn) overlap <= overlap + 1;
        cyc <= cyc + 1;
    end

    // Reference model: expected screen contents and cursor
    logic [31:0] refmem [TOTAL];
    int mrow;
    int mcol;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input bit ready_exp);
        chk("idle_strobes", 32'({memReadEn, memWriteEn}), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("cursor_row", 32'(cursorRow), 32'(mrow));
        chk("cursor_col", 32'(cursorCol), 32'(mcol));
        chk("ready", 32'(charReady), 32'(ready_exp));
    endtask

    // Sends one character and checks the full response; entered and left
    // 1 time unit after a rising edge.
    task automatic do_char(input logic [7:0] ch, input bit pulse_clear, output int acc_cyc);
        int lin, w, k, n;
        bit memop;
        logic [7:0]  wch;
        logic [31:0] mask, exp_data;
        memop = 0;
        wch   = ch;
        lin   = 0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            memop = 1;
            lin   = mrow * HORZ + mcol;
        end else if (ch == 8'h08 && mcol > 0) begin
            memop = 1;
            wch   = 8'h20;
            lin   = mrow * HORZ + mcol - 1;
        end
        w        = lin / 4;
        k        = lin % 4;
        mask     = 32'hFF << (24 - 8 * k);
        exp_data = (refmem[w] & ~mask) | ({24'h0, wch} << (24 - 8 * k));

        charData  = ch;
        charValid = 1'b1;
        n = 0;
        while (!charReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(charReady), 32'd1);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        charValid = 1'b0;

        if (memop) begin
            if (pulse_clear) clearReq = 1'b1;
            chk("rd_en", 32'(memReadEn), 32'd1);
            chk("rd_we_low", 32'(memWriteEn), 32'd0);
            chk("rd_add", memReadAdd, 32'(w));
            chk("rd_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
            clearReq = 1'b0;
            chk("merge_strobes", 32'({memReadEn, memWriteEn}), 32'd0);
            @(posedge clk); #1;
            chk("wr_en", 32'(memWriteEn), 32'd1);
            chk("wr_re_low", 32'(memReadEn), 32'd0);
            chk("wr_add", memWriteAdd, 32'(w));
            chk("wr_data", memWriteData, exp_data);
            refmem[w] = exp_data;
            if (ch == 8'h08) begin
                mcol--;
            end else begin
                mcol++;
                if (mcol == HORZ) begin
                    mcol = 0;
                    mrow = (mrow + 1) % VERT;
                end
            end
            @(posedge clk); #1;
        end else if (ch == 8'h0A) begin
            mcol = 0;
            mrow = (mrow + 1) % VERT;
        end else if (ch == 8'h0D) begin
            mcol = 0;
        end
        check_idle(!pulse_clear);
    endtask

    function automatic logic [7:0] rand_printable();
        return 8'($urandom_range(32, 126));
    endfunction

    logic [7:0] abcde [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    logic [7:0] junk  [5] = '{8'h00, 8'h1B, 8'h7F, 8'hFF, 8'h09};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int acc [5];
        int a;
        int sel;
        logic [31:0] tmp;

        rst       = 1'b1;
        charValid = 1'b0;
        charData  = 8'h00;
        clearReq  = 1'b0;
        mem_load  = 1'b1;
        for (int i = 0; i < MEMW; i++) seed[i] = (i < 2) ? 32'h0 : $urandom;
        for (int i = 0; i < TOTAL; i++) refmem[i] = seed[i];
        mrow = 0;
        mcol = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;
        chk("rst_ready", 32'(charReady), 32'd0);
        chk("rst_rd_en", 32'(memReadEn), 32'd0);
        chk("rst_wr_en", 32'(memWriteEn), 32'd0);
        chk("rst_rd_add", memReadAdd, 32'd0);
        chk("rst_wr_add", memWriteAdd, 32'd0);
        chk("rst_wr_data", memWriteData, 32'd0);
        chk("rst_row", 32'(cursorRow), 32'd0);
        chk("rst_col", 32'(cursorCol), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(charReady), 32'd1);

        // Single 'A' at (0,0)
        do_char(8'h41, 0, a);
        chk("t1_word0", mem[0], 32'h41000000);
        chk("t1_col", 32'(cursorCol), 32'd1);

        // "ABCDE" back-to-back from column 0
        do_char(8'h0D, 0, a);
        for (int i = 0; i < 5; i++) do_char(abcde[i], 0, acc[i]);
        for (int i = 1; i < 5; i++) chk("t2_gap", 32'(acc[i] - acc[i-1]), 32'd4);
        chk("t2_word0", mem[0], 32'h41424344);
        chk("t2_word1", mem[1], 32'h45000000);
        chk("t2_col", 32'(cursorCol), 32'd5);

        // Backspace over "ABCD" from column 3, then backspace at column 0
        do_char(8'h0D, 0, a);
        for (int i = 0; i < 3; i++) do_char(abcde[i], 0, a);
        do_char(8'h08, 0, a);
        chk("t4_word0", mem[0], 32'h41422044);
        chk("t4_col", 32'(cursorCol), 32'd2);
        do_char(8'h0D, 0, a);
        do_char(8'h08, 0, a);

        // Row wrap at end of line and at bottom of screen
        for (int i = 0; i < 79; i++) do_char(rand_printable(), 0, a);
        do_char(8'h5A, 0, a);
        tmp = mem[19];
        chk("t3_w19_byte3", 32'(tmp[7:0]), 32'h5A);
        chk("t3_row", 32'(cursorRow), 32'd1);
        for (int i = 0; i < 28; i++) do_char(8'h0A, 0, a);
        for (int i = 0; i < 79; i++) do_char(rand_printable(), 0, a);
        do_char(8'h5A, 0, a);
        tmp = mem[599];
        chk("t3_w599_byte3", 32'(tmp[7:0]), 32'h5A);
        chk("t3_wrap_row", 32'(cursorRow), 32'd0);
        chk("t3_wrap_col", 32'(cursorCol), 32'd0);
        for (int i = 0; i < 29; i++) do_char(8'h0A, 0, a);
        do_char(8'h0A, 0, a);

        // Random mix of printable, control and ignored codes
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      do_char(rand_printable(), 0, a);
            else if (sel == 6) do_char(8'h0A, 0, a);
            else if (sel == 7) do_char(8'h0D, 0, a);
            else if (sel == 8) do_char(8'h08, 0, a);
            else               do_char(junk[$urandom_range(0, 4)], 0, a);
        end

        // Clear requested while a character is in RD
        do_char(rand_printable(), 1, a);
        for (int i = 0; i < TOTAL; i++) begin
            @(posedge clk); #1;
            chk("clr_write", {memWriteEn, memReadEn, charReady, busy, 28'(memWriteAdd)},
                {1'b1, 1'b0, 1'b0, 1'b1, 28'(i)});
            chk("clr_data", memWriteData, 32'h20202020);
            refmem[i] = 32'h20202020;
        end
        @(posedge clk); #1;
        mrow = 0;
        mcol = 0;
        check_idle(1'b1);

        // Reset asserted while in MERGE aborts the write
        do_char(8'h0D, 0, a);
        do_char(8'h41, 0, a);
        charData  = rand_printable();
        charValid = 1'b1;
        @(posedge clk); #1;
        charValid = 1'b0;
        chk("t6_rd_en", 32'(memReadEn), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mrow = 0;
        mcol = 0;
        check_idle(1'b0);
        @(posedge clk); #1;
        chk("t6_no_write", 32'(memWriteEn), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle(1'b1);

        // Whole-buffer comparison against the model
        for (int i = 0; i < TOTAL; i++) chk("mem_sweep", mem[i], refmem[i]);
        chk("mem_beyond", mem[TOTAL], seed[TOTAL]);
        chk("strobe_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
